led_frame_scan: RTL and testbench



---
 rtl/led_frame_scan.sv | 153 +++++++++++++++
 tb/tb_led_frame_scan.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scan.sv
// led_frame_scan
//
// Frame sequencer that sits directly upstream of idx2addr. A start request
// walks LED indices 0..LED_NUM-1. For each LED it presents idx_out/en_out,
// waits FETCH_LAT cycles for the address register and the colour RAM read,
// then pulses data_vld_out to the WS2812 serializer and holds the index until
// the serializer reports the LED done. After the last LED the serializer is
// held in latch (line low) for RST_CYCLES clocks, and frame_done_out pulses.
//
// Handshake: start_in and led_done_in are level-sampled on the rising clock
// edge, with no ready/acknowledge path back to the requester. start_in is
// accepted only in IDLE; while busy_out is high it is dropped, not queued.
// led_done_in is accepted only in SEND, and only from the second SEND cycle
// on, so a done pulse left over from the previous LED cannot skip an index.
//
// Ports
//   clk_in          system clock
//   rst_n_in        synchronous active-low reset
//   start_in        frame start request (sampled in IDLE only)
//   led_done_in     serializer: 24 bits of the current LED shifted out
//   en_out          enable to idx2addr
//   idx_out [5:0]   LED index to idx2addr
//   data_vld_out    one-cycle pulse: colour data for idx_out valid
//   latch_out       serializer must hold the line low
//   busy_out        high in every state except IDLE
//   frame_done_out  one-cycle pulse at frame end
//
// Every output is a flop. The next-state process also computes the next
// output values from the next state, so outputs change together with state.
module led_frame_scan #(
    parameter int LED_NUM    = 64,
    parameter int FETCH_LAT  = 2,
    parameter int RST_CYCLES = 15000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic       led_done_in,
    output logic       en_out,
    output logic [5:0] idx_out,
    output logic       data_vld_out,
    output logic       latch_out,
    output logic       busy_out,
    output logic       frame_done_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0]  LAST_IDX  = 6'(LED_NUM - 1);
    localparam logic [3:0]  FETCH_END = 4'(FETCH_LAT - 1);
    localparam logic [15:0] LATCH_END = 16'(RST_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  fetch_cnt;
    logic [3:0]  fetch_cnt_nxt;
    logic [15:0] latch_cnt;
    logic [15:0] latch_cnt_nxt;
    logic [5:0]  idx_nxt;
    logic        en_nxt;
    logic        vld_nxt;
    logic        latch_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            fetch_cnt      <= 4'd0;
            latch_cnt      <= 16'd0;
            en_out         <= 1'b0;
            idx_out        <= 6'd0;
            data_vld_out   <= 1'b0;
            latch_out      <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            fetch_cnt      <= fetch_cnt_nxt;
            latch_cnt      <= latch_cnt_nxt;
            en_out         <= en_nxt;
            idx_out        <= idx_nxt;
            data_vld_out   <= vld_nxt;
            latch_out      <= latch_nxt;
            busy_out       <= busy_nxt;
            frame_done_out <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx_out;
        fetch_cnt_nxt = 4'd0;
        latch_cnt_nxt = 16'd0;

        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = FETCH;
                    idx_nxt   = 6'd0;
                end
            end
            FETCH: begin
                // Counter runs 0..FETCH_LAT-1, so FETCH lasts FETCH_LAT cycles.
                if (fetch_cnt == FETCH_END) begin
                    state_nxt = SEND;
                end else begin
                    fetch_cnt_nxt = fetch_cnt + 4'd1;
                end
            end
            SEND: begin
                // data_vld_out is high only in the first SEND cycle; it doubles
                // as the "ignore led_done_in this cycle" flag.
                if (led_done_in && !data_vld_out) begin
                    if (idx_out == LAST_IDX) begin
                        state_nxt = LATCH;
                        idx_nxt   = 6'd0;
                    end else begin
                        state_nxt = FETCH;
                        idx_nxt   = idx_out + 6'd1;
                    end
                end
            end
            LATCH: begin
                if (latch_cnt == LATCH_END) begin
                    state_nxt = DONE;
                end else begin
                    latch_cnt_nxt = latch_cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 6'd0;
            end
        endcase

        en_nxt    = (state_nxt == FETCH) || (state_nxt == SEND);
        vld_nxt   = (state == FETCH) && (state_nxt == SEND);
        latch_nxt = (state_nxt == LATCH);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_led_frame_scan.sv
// Bench for led_frame_scan. Two instances: dut_a (64 LEDs, FETCH_LAT 2,
// RST_CYCLES 10) and dut_b (1 LED, FETCH_LAT 1, RST_CYCLES 1). A select
// signal routes the shared stimulus to one instance and its outputs to the
// monitor. Cycle n of a frame run is the interval after the n-th sampling
// negedge; inputs driven in cycle n are taken by the DUT at the next posedge.
// Expected event times come from the timing rules: first data valid at
// 1+FETCH_LAT, next LED's data valid at done+1+FETCH_LAT, latch from
// last_done+1 for RST_CYCLES cycles, frame_done at last_done+RST_CYCLES+1.
module tb_led_frame_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic led_done;
    logic sel;

    logic       start_a, start_b, done_a, done_b;
    logic       en_a, vld_a, latch_a, busy_a, fdone_a;
    logic       en_b, vld_b, latch_b, busy_b, fdone_b;
    logic [5:0] idx_a, idx_b;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign done_a  = led_done && !sel;
    assign done_b  = led_done && sel;

    led_frame_scan #(.LED_NUM(64), .FETCH_LAT(2), .RST_CYCLES(10)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .led_done_in(done_a),
        .en_out(en_a), .idx_out(idx_a), .data_vld_out(vld_a), .latch_out(latch_a),
        .busy_out(busy_a), .frame_done_out(fdone_a)
    );

    led_frame_scan #(.LED_NUM(1), .FETCH_LAT(1), .RST_CYCLES(1)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .led_done_in(done_b),
        .en_out(en_b), .idx_out(idx_b), .data_vld_out(vld_b), .latch_out(latch_b),
        .busy_out(busy_b), .frame_done_out(fdone_b)
    );

    logic       c_en, c_vld, c_latch, c_busy, c_fdone;
    logic [5:0] c_idx;
    assign c_en    = sel ? en_b    : en_a;
    assign c_vld   = sel ? vld_b   : vld_a;
    assign c_latch = sel ? latch_b : latch_a;
    assign c_busy  = sel ? busy_b  : busy_a;
    assign c_fdone = sel ? fdone_b : fdone_a;
    assign c_idx   = sel ? idx_b   : idx_a;

    int checks   = 0;
    int failures = 0;

    // Parameters of the selected instance.
    int fl, rc, ln;

    // Records from the last frame run.
    int vld_cyc[$];
    int vld_idx[$];
    int done_cyc[$];
    int latch_cnt, latch_first, fdone_cnt, fdone_cyc, busy_low_cyc, busy_after;
    int en_bad, idx_bad, abort_cyc;
    bit timeout;
    logic [10:0] snap;

    // Drives one frame with a mock serializer and records what the DUT did.
    // dlo/dhi: done delay after each data valid; stray: extra done pulses in the
    // first SEND cycle and the cycle after each real done; busy_idx: restart
    // requests while at that index and during latch; abort_idx: one-cycle reset
    // at that index; tail: cycles to watch after frame_done/abort.
    task automatic run_frame(input int dlo, input int dhi, input bit stray,
                             input int busy_idx, input int abort_idx,
                             input int tail, input bit pre_started);
        int next_done;
        bit finished;
        vld_cyc.delete(); vld_idx.delete(); done_cyc.delete();
        latch_cnt = 0; latch_first = -1; fdone_cnt = 0; fdone_cyc = -1;
        busy_low_cyc = -1; busy_after = 0; en_bad = 0; idx_bad = 0;
        abort_cyc = -1; timeout = 1'b0; snap = '1;
        next_done = -1; finished = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (c_vld === 1'b1) begin
                vld_cyc.push_back(n);
                vld_idx.push_back(int'(c_idx));
                next_done = n + int'($urandom_range(dhi, dlo));
            end
            if (c_latch === 1'b1) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = n;
            end
            if (fdone_cyc >= 0 && n > fdone_cyc) begin
                if (c_busy !== 1'b0) busy_after++;
                else if (busy_low_cyc < 0) busy_low_cyc = n;
            end
            if (c_fdone === 1'b1) begin
                fdone_cnt++;
                fdone_cyc = n;
            end
            if (c_en !== (c_busy && !c_latch && !c_fdone)) en_bad++;
            if (int'(c_idx) > ln - 1) idx_bad++;
            if (abort_cyc >= 0 && n == abort_cyc + 1)
                snap = {c_en, c_idx, c_vld, c_latch, c_busy, c_fdone};
            if ((fdone_cyc >= 0 && n >= fdone_cyc + tail) ||
                (abort_cyc >= 0 && n >= abort_cyc + tail)) begin
                finished = 1'b1;
                break;
            end
            start    = (n == 0) && !pre_started;
            led_done = 1'b0;
            rst_n    = 1'b1;
            if (n == next_done) begin
                led_done = 1'b1;
                done_cyc.push_back(n);
            end
            if (stray && c_vld === 1'b1) led_done = 1'b1;
            if (stray && done_cyc.size() > 0 && n == done_cyc[$] + 1) led_done = 1'b1;
            if (busy_idx >= 0 && ((c_en === 1'b1 && int'(c_idx) == busy_idx) || c_latch === 1'b1))
                start = 1'b1;
            if (abort_idx >= 0 && abort_cyc < 0 && c_en === 1'b1 && int'(c_idx) == abort_idx) begin
                rst_n     = 1'b0;
                abort_cyc = n;
                next_done = -1;
            end
        end
        if (!finished) timeout = 1'b1;
        start    = 1'b0;
        led_done = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; led_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({en_a, idx_a, vld_a, latch_a, busy_a, fdone_a} !== 11'd0) begin
            failures++;
            $display("FAIL reset_a: got %b expected 0", {en_a, idx_a, vld_a, latch_a, busy_a, fdone_a});
        end
        checks++;
        if ({en_b, idx_b, vld_b, latch_b, busy_b, fdone_b} !== 11'd0) begin
            failures++;
            $display("FAIL reset_b: got %b expected 0", {en_b, idx_b, vld_b, latch_b, busy_b, fdone_b});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({en_a, idx_a, vld_a, latch_a, busy_a, fdone_a} !== 11'd0) begin
            failures++;
            $display("FAIL idle_a: got %b expected 0", {en_a, idx_a, vld_a, latch_a, busy_a, fdone_a});
        end
        checks++;
        if ({en_b, idx_b, vld_b, latch_b, busy_b, fdone_b} !== 11'd0) begin
            failures++;
            $display("FAIL idle_b: got %b expected 0", {en_b, idx_b, vld_b, latch_b, busy_b, fdone_b});
        end
    endtask

    task automatic test_single_frame();
        int order_err;
        int timing_err;
        int d_last;
        sel = 1'b0; fl = 2; rc = 10; ln = 64;
        run_frame(24, 24, 1'b0, -1, -1, 4, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL single_timeout: frame did not finish"); end
        checks++;
        if (vld_cyc.size() != ln) begin
            failures++; $display("FAIL single_vld_count: got %0d expected %0d", vld_cyc.size(), ln);
        end
        order_err = 0;
        timing_err = 0;
        foreach (vld_idx[k]) if (vld_idx[k] != k) order_err++;
        foreach (vld_cyc[k]) begin
            if (k == 0) begin
                if (vld_cyc[k] != 1 + fl) timing_err++;
            end else if (k - 1 < done_cyc.size()) begin
                if (vld_cyc[k] != done_cyc[k-1] + 1 + fl) timing_err++;
            end else begin
                timing_err++;
            end
        end
        checks++;
        if (order_err != 0) begin failures++; $display("FAIL single_idx_order: got %0d misordered expected 0", order_err); end
        checks++;
        if (vld_cyc.size() == 0 || vld_cyc[0] != 3) begin
            failures++; $display("FAIL single_first_vld: got %0d expected 3", vld_cyc.size() ? vld_cyc[0] : -1);
        end
        checks++;
        if (timing_err != 0) begin failures++; $display("FAIL single_vld_timing: got %0d late/early expected 0", timing_err); end
        d_last = (done_cyc.size() >= ln) ? done_cyc[ln-1] : -100;
        checks++;
        if (latch_cnt != rc) begin failures++; $display("FAIL single_latch_len: got %0d expected %0d", latch_cnt, rc); end
        checks++;
        if (latch_first != d_last + 1) begin
            failures++; $display("FAIL single_latch_start: got %0d expected %0d", latch_first, d_last + 1);
        end
        checks++;
        if (fdone_cnt != 1) begin failures++; $display("FAIL single_fdone_count: got %0d expected 1", fdone_cnt); end
        checks++;
        if (fdone_cyc != d_last + rc + 1) begin
            failures++; $display("FAIL single_fdone_cycle: got %0d expected %0d", fdone_cyc, d_last + rc + 1);
        end
        checks++;
        if (busy_low_cyc != d_last + rc + 2 || busy_after != 0) begin
            failures++; $display("FAIL single_busy_low: got %0d expected %0d", busy_low_cyc, d_last + rc + 2);
        end
        checks++;
        if (fdone_cyc + 1 != ln * (fl + 25) + rc + 2) begin
            failures++; $display("FAIL single_frame_len: got %0d expected %0d", fdone_cyc + 1, ln * (fl + 25) + rc + 2);
        end
        checks++;
        if (en_bad != 0 || idx_bad != 0) begin
            failures++; $display("FAIL single_en_idx: got en_bad=%0d idx_bad=%0d expected 0", en_bad, idx_bad);
        end
    endtask

    task automatic test_stray_done();
        int timing_err;
        sel = 1'b0; fl = 2; rc = 10; ln = 64;
        // Done pulses while idle must not start anything.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (c_busy !== 1'b0 || c_en !== 1'b0) begin
                failures++; $display("FAIL stray_idle: got busy=%b en=%b expected 0", c_busy, c_en);
            end
            led_done = 1'b1;
        end
        @(negedge clk);
        led_done = 1'b0;
        checks++;
        if (c_busy !== 1'b0) begin failures++; $display("FAIL stray_idle_end: got busy=%b expected 0", c_busy); end
        run_frame(1, 12, 1'b1, -1, -1, 3, 1'b0);
        checks++;
        if (timeout || vld_cyc.size() != ln) begin
            failures++; $display("FAIL stray_vld_count: got %0d expected %0d", vld_cyc.size(), ln);
        end
        timing_err = 0;
        foreach (vld_cyc[k]) begin
            if (vld_idx[k] != k) timing_err++;
            if (k == 0) begin
                if (vld_cyc[k] != 1 + fl) timing_err++;
            end else if (k - 1 >= done_cyc.size() || vld_cyc[k] != done_cyc[k-1] + 1 + fl) begin
                timing_err++;
            end
        end
        checks++;
        if (timing_err != 0) begin failures++; $display("FAIL stray_timing: got %0d errors expected 0", timing_err); end
        checks++;
        if (fdone_cnt != 1 || done_cyc.size() < ln || fdone_cyc != done_cyc[ln-1] + rc + 1) begin
            failures++; $display("FAIL stray_fdone: got count=%0d cycle=%0d", fdone_cnt, fdone_cyc);
        end
        checks++;
        if (latch_cnt != rc) begin failures++; $display("FAIL stray_latch_len: got %0d expected %0d", latch_cnt, rc); end
    endtask

    task automatic test_start_busy();
        sel = 1'b0; fl = 2; rc = 10; ln = 64;
        run_frame(2, 6, 1'b0, 10, -1, 8, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL busy_timeout: frame did not finish"); end
        checks++;
        if (fdone_cnt != 1) begin failures++; $display("FAIL busy_fdone_count: got %0d expected 1", fdone_cnt); end
        checks++;
        if (vld_cyc.size() != ln) begin
            failures++; $display("FAIL busy_vld_count: got %0d expected %0d", vld_cyc.size(), ln);
        end
        checks++;
        if (busy_after != 0 || busy_low_cyc != fdone_cyc + 1) begin
            failures++; $display("FAIL busy_restart: got busy_after=%0d low=%0d expected 0 %0d", busy_after, busy_low_cyc, fdone_cyc + 1);
        end
        checks++;
        if (en_bad != 0) begin failures++; $display("FAIL busy_en: got %0d bad cycles expected 0", en_bad); end
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b0; fl = 2; rc = 10; ln = 64;
        run_frame(1, 5, 1'b0, -1, 37, 6, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL abort_timeout: index 37 never reached"); end
        checks++;
        if (snap !== 11'd0) begin failures++; $display("FAIL abort_outputs: got %b expected 0", snap); end
        checks++;
        if (fdone_cnt != 0 || latch_cnt != 0) begin
            failures++; $display("FAIL abort_no_done: got fdone=%0d latch=%0d expected 0", fdone_cnt, latch_cnt);
        end
        checks++;
        if (vld_cyc.size() != 37) begin failures++; $display("FAIL abort_vld_count: got %0d expected 37", vld_cyc.size()); end
        run_frame(1, 5, 1'b0, -1, -1, 2, 1'b0);
        checks++;
        if (vld_idx.size() == 0 || vld_idx[0] != 0 || vld_cyc[0] != 1 + fl) begin
            failures++; $display("FAIL abort_restart: got idx=%0d cyc=%0d expected 0 %0d",
                                 vld_idx.size() ? vld_idx[0] : -1, vld_cyc.size() ? vld_cyc[0] : -1, 1 + fl);
        end
        checks++;
        if (timeout || vld_cyc.size() != ln || fdone_cnt != 1) begin
            failures++; $display("FAIL abort_full_frame: got vld=%0d fdone=%0d expected %0d 1", vld_cyc.size(), fdone_cnt, ln);
        end
    endtask

    task automatic test_boundary();
        int d;
        sel = 1'b1; fl = 1; rc = 1; ln = 1;
        @(negedge clk);
        run_frame(1, 3, 1'b0, -1, -1, 1, 1'b0);
        d = (done_cyc.size() > 0) ? done_cyc[0] : -100;
        checks++;
        if (timeout) begin failures++; $display("FAIL bnd_timeout: frame did not finish"); end
        checks++;
        if (vld_cyc.size() != 1 || vld_idx[0] != 0 || vld_cyc[0] != 2) begin
            failures++; $display("FAIL bnd_vld: got count=%0d cyc=%0d expected 1 2", vld_cyc.size(), vld_cyc.size() ? vld_cyc[0] : -1);
        end
        checks++;
        if (latch_cnt != 1 || latch_first != d + 1) begin
            failures++; $display("FAIL bnd_latch: got len=%0d start=%0d expected 1 %0d", latch_cnt, latch_first, d + 1);
        end
        checks++;
        if (fdone_cnt != 1 || fdone_cyc != d + 2) begin
            failures++; $display("FAIL bnd_fdone: got count=%0d cyc=%0d expected 1 %0d", fdone_cnt, fdone_cyc, d + 2);
        end
        checks++;
        if (busy_low_cyc != d + 3) begin failures++; $display("FAIL bnd_busy_low: got %0d expected %0d", busy_low_cyc, d + 3); end
        checks++;
        if (en_bad != 0 || idx_bad != 0) begin
            failures++; $display("FAIL bnd_en_idx: got en_bad=%0d idx_bad=%0d expected 0", en_bad, idx_bad);
        end
        // Earliest legal restart: the first cycle with busy_out low.
        start = 1'b1;
        run_frame(1, 3, 1'b0, -1, -1, 2, 1'b1);
        checks++;
        if (timeout || vld_cyc.size() != 1 || vld_cyc[0] != fl) begin
            failures++; $display("FAIL bnd_b2b_vld: got count=%0d cyc=%0d expected 1 %0d",
                                 vld_cyc.size(), vld_cyc.size() ? vld_cyc[0] : -1, fl);
        end
        checks++;
        if (fdone_cnt != 1 || latch_cnt != 1) begin
            failures++; $display("FAIL bnd_b2b_done: got fdone=%0d latch=%0d expected 1 1", fdone_cnt, latch_cnt);
        end
    endtask

    initial begin
        sel = 1'b0; fl = 2; rc = 10; ln = 64;
        rst_n = 1'b0; start = 1'b0; led_done = 1'b0;
        test_reset();
        test_single_frame();
        test_stray_done();
        test_start_busy();
        test_reset_mid_frame();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
